// File: rtl/io_port_responder.sv
// Peripheral endpoint of the CPU_B IO channel: latches a port address, writes
// output-port registers and returns input-port holding data or status on the shared bus.
module io_port_responder #(
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        set_output,
  input  logic        enable_input,
  input  logic        data_address,
  inout  wire  [7:0]  cpu_in_out,
  input  logic [31:0] port_in,
  input  logic [3:0]  port_in_valid,
  output logic [31:0] port_out,
  output logic [3:0]  out_strobe,
  output logic [3:0]  in_flag
);

  logic [7:0]      addr_q, addr_d;
  logic [3:0][7:0] po_q, po_d;
  logic [3:0]      strobe_q, strobe_d;
  logic [3:0][7:0] hold_q, hold_d;
  logic [3:0]      flag_q, flag_d;
  logic [3:0]      pend_q, pend_d;
  logic [3:0][7:0] pdata_q, pdata_d;
  logic            set_q, en_q;

  logic       set_rise, en_fall, rd_active, port_ok, stat_sel, drive;
  logic [7:0] sel_port;
  logic [1:0] sel_k;
  logic [3:0] port_hit;
  logic [7:0] bus_out;

  assign set_rise  = set_output & ~set_q;
  assign en_fall   = ~enable_input & en_q;
  assign sel_port  = addr_q - BASE_ADDR;
  assign sel_k     = sel_port[1:0];
  assign port_ok   = (sel_port < 8'd4);
  assign stat_sel  = (sel_port == 8'd4);
  assign port_hit  = port_ok ? (4'b0001 << sel_k) : 4'b0000;
  assign rd_active = enable_input & ~data_address;

  // Reset also gates the drive so the bus is released in the same cycle.
  assign drive = rd_active & (port_ok | stat_sel) & ~reset;

  always_comb begin
    bus_out = {4'b0000, flag_q};
    if (port_ok) bus_out = hold_q[sel_k];
  end

  assign cpu_in_out = drive ? bus_out : 8'hzz;

  always_comb begin
    addr_d   = addr_q;
    po_d     = po_q;
    strobe_d = 4'b0000;
    hold_d   = hold_q;
    flag_d   = flag_q;
    pend_d   = pend_q;
    pdata_d  = pdata_q;

    if (set_rise) begin
      if (data_address) begin
        addr_d = cpu_in_out;
      end else if (port_ok) begin
        po_d[sel_k]     = cpu_in_out;
        strobe_d[sel_k] = 1'b1;
      end
    end

    for (int k = 0; k < 4; k++) begin
      if (en_fall && !data_address && port_hit[k]) begin
        flag_d[k] = 1'b0;
        if (pend_q[k]) begin
          hold_d[k] = pdata_q[k];
          flag_d[k] = 1'b1;
          pend_d[k] = 1'b0;
        end
      end
      // A load arriving mid-read is parked so the CPU sees stable data.
      if (port_in_valid[k]) begin
        if (rd_active && port_hit[k]) begin
          pend_d[k]  = 1'b1;
          pdata_d[k] = port_in[8*k +: 8];
        end else begin
          hold_d[k] = port_in[8*k +: 8];
          flag_d[k] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q   <= 8'h00;
      po_q     <= '0;
      strobe_q <= 4'b0000;
      hold_q   <= '0;
      flag_q   <= 4'b0000;
      pend_q   <= 4'b0000;
      pdata_q  <= '0;
      set_q    <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      po_q     <= po_d;
      strobe_q <= strobe_d;
      hold_q   <= hold_d;
      flag_q   <= flag_d;
      pend_q   <= pend_d;
      pdata_q  <= pdata_d;
      set_q    <= set_output;
      en_q     <= enable_input;
    end
  end

  assign port_out   = po_q;
  assign out_strobe = strobe_q;
  assign in_flag    = flag_q;

endmodule

// File: doc/io_port_responder.md
# io_port_responder

Peripheral-side endpoint of the CPU_B IO channel. Decodes the CPU's `set_output`, `enable_input` and `data_address` strobes and the shared bidirectional `cpu_in_out` bus. Latches an 8-bit port address, writes addressed output-port registers, and drives addressed input-port holding registers or a status byte back onto the bus. Sits outside the CPU, between the IO channel and up to four external devices.

## Interface
- `BASE_ADDR`, 8'h00: first address of the block's window. Ports occupy BASE..BASE+3; status is at BASE+4; all other addresses are unselected.
- `clk` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `set_output` input 1: CPU output strobe (level; only its rising edge acts).
- `enable_input` input 1: CPU input strobe (level; block drives the bus while it is high).
- `data_address` input 1: 0 = data transfer, 1 = address transfer.
- `cpu_in_out` inout 8: shared IO bus.
- `port_in` input 32: four 8-bit device inputs; port k is bits [8k+7:8k].
- `port_in_valid` input 4: per-port load request, sampled each clock.
- `port_out` output 32: four registered 8-bit output ports.
- `out_strobe` output 4: one-cycle pulse per output port on write.
- `in_flag` output 4: per-port "unread data held" flags; same value as the status byte.

## Operation
- Reset value of every register:
  - `addr_reg` = 8'h00.
  - `port_out` = 0.
  - `in_hold[0..3]` = 0.
  - `in_flag` = 0, `pend` = 0.
  - `out_strobe` = 0.
  - `set_q` = 0, `en_q` = 0.
  - Bus is released (Z).
- Edge detection:
  - `set_q` and `en_q` are the previous-cycle samples of `set_output` and `enable_input`.
  - `set_rise` = `set_output & !set_q`.
  - `en_fall` = `!enable_input & en_q`.
- Decode:
  - `sel_port` = `addr_reg - BASE_ADDR`, computed 8-bit with wrap-around.
  - The port is valid when `sel_port` < 4. Status is selected when `sel_port` == 4.
- Address write: on `set_rise` with `data_address`=1, `addr_reg` <= `cpu_in_out`.
- Data write: on `set_rise` with `data_address`=0 and a valid port k:
  - `port_out[k]` <= bus.
  - `out_strobe[k]` = 1 for exactly that next cycle.
  - Writes to status or to an unselected address are ignored, with no strobe.
- Read drive (combinational): the block drives the bus only when `enable_input`=1, `data_address`=0 and the address is selected.
  - Valid port k: bus = `in_hold[k]`.
  - Status: bus = {4'b0, `in_flag`}.
  - Otherwise: Z.
  - The block never drives while `data_address`=1 or `enable_input`=0.
- Input load, per port k, when `port_in_valid[k]`=1:
  - If port k is not currently being read: `in_hold[k]` <= `port_in[k]`, `in_flag[k]` <= 1.
  - If port k is being read (`enable_input`=1, `data_address`=0, `sel_port`=k): the load is blocked, `pend[k]` <= 1, and `pend_data[k]` <= `port_in[k]`. The last value received wins.
- Read completion: on `en_fall` with `data_address`=0 and valid port k, `in_flag[k]` <= 0.
  - If `pend[k]` is set in that same cycle: `in_hold[k]` <= `pend_data[k]`, `in_flag[k]` <= 1, `pend[k]` <= 0. The load wins over the clear.
- A status read clears nothing.
- Simultaneous `port_in_valid[k]` and `en_fall` on port k: the new data loads and `in_flag[k]` stays 1.
- `set_output` and `enable_input` both high is a CPU protocol error. The write still executes; the drive rules are unchanged.

## Timing
- Write latency: `port_out[k]` and `out_strobe[k]` change at the first clock edge that samples `set_output`=1.
  - A `set_output` held high for N cycles produces exactly one write.
- Read latency: zero cycles, combinational from `enable_input`/`addr_reg` to the bus.
  - Held data is stable for the whole strobe.
- Flag clear: effective at the clock edge that first samples `enable_input`=0 after a high.
- Input load visible in `in_hold` and `in_flag` one cycle after `port_in_valid`.
- Reset asserted mid-transfer:
  - All registers clear immediately and the bus goes Z in the same cycle.
  - Pending loads are discarded.

## Test plan
- Reset, then pulse `set_output` with `data_address`=1 and bus 8'h02, then pulse `set_output` with `data_address`=0 and bus 8'hA5:
  - `port_out[23:16]` = 8'hA5.
  - `out_strobe` = 4'b0100 for one cycle.
  - Other ports stay 0.
- Hold `set_output` high for 5 cycles with data 8'h3C to port 0: exactly one `out_strobe[0]` pulse; `port_out[7:0]` = 8'h3C.
- `port_in_valid[1]` with 8'h77, address 1, `enable_input` high:
  - Bus = 8'h77.
  - After `enable_input` falls, `in_flag[1]` = 0.
  - The status read (address 4) returns 8'h00.
- During a read of port 1, pulse `port_in_valid[1]` with 8'h99:
  - Bus holds the old value for the whole strobe.
  - After the fall, `in_hold[1]` = 8'h99 and `in_flag[1]` = 1.
- Address 8'h09 with BASE_ADDR=0: a write does nothing and a read leaves the bus Z. `data_address`=1 with `enable_input`=1 leaves the bus Z.
- Assert `reset` while `enable_input` is high on port 2: the bus goes Z immediately and all outputs are 0.
